// File: rtl/uart_rx_param_if.sv
// Receive-side word handshake between uart_rx_param and its consumer.
// Carries o_data/o_par_err/o_frm_err with o_valid/i_ready, plus the o_overrun pulse.
// master = receiver (drives word, status, valid, overrun); slave = consumer (drives i_ready).
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_par_err;
  logic                 o_frm_err;
  logic                 o_overrun;

  modport master (
    output o_data, o_valid, o_par_err, o_frm_err, o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_par_err, o_frm_err, o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop sync, start qualification, mid-bit sampling, parity/stop check.
// Latency: RX falling edge -> o_busy 3 clocks; last stop sample -> o_valid 1 clock.
// Backpressure: 1-entry output register; a frame completing while it is full and not accepted is dropped (o_overrun pulse).
// Ports: i_clk, i_rst (async, active-high), i_rx_data (serial, idle high), o_busy,
//        rx (uart_rx_param_if.master: o_data, o_valid, i_ready, o_par_err, o_frm_err, o_overrun).
// Option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit (decision one clock later).
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_rx_data,
  output logic            o_busy,
  uart_rx_param_if.master rx
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMP_DLY = 1;
`else
  localparam int SAMP_DLY = 0;
`endif
  // Start bit is decided half a bit in; every later sample is a full bit after
  // the previous one, so the majority delay only shifts the first decision.
  localparam logic [CW-1:0] START_LAST = CW'(HALF - 1 + SAMP_DLY);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s, rx_s_d;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err, frm_err, done;
  logic                 fell, tick, samp, last_data, last_stop;

  // Sync flops reset high so reset release on an idle line is not a start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= i_rx_data;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist[0] = rx_s at mid, hist[1] = rx_s at mid-1 when the decision is taken at mid+1.
  logic [1:0] hist;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) hist <= 2'b11;
    else       hist <= {hist[0], rx_s};
  end
  assign samp = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign samp = rx_s;
`endif

  assign fell      = !rx_s && rx_s_d;
  assign tick      = (state == S_START) ? (cnt == START_LAST) : (cnt == BIT_LAST);
  assign last_data = (bit_idx == 4'(DATA_BITS - 1));
  assign last_stop = (bit_idx == 4'(STOP_BITS - 1));
  assign o_busy    = (state != S_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (fell) state_nxt = S_START;
      S_START:  if (tick) state_nxt = samp ? S_IDLE : S_DATA;
      S_DATA:   if (tick && last_data) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nxt = S_STOP;
      // Leave at mid-stop so a start edge half a bit later is still caught.
      S_STOP:   if (tick && last_stop) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE || tick) cnt <= '0;
      else                         cnt <= cnt + CW'(1);
      if (state_nxt != state) bit_idx <= '0;
      else if (tick)          bit_idx <= bit_idx + 4'd1;
      case (state)
        S_IDLE: if (fell) begin
          par_err <= 1'b0;
          frm_err <= 1'b0;
        end
        S_DATA:   if (tick) shift <= {samp, shift[DATA_BITS-1:1]};
        S_PARITY: if (tick) par_err <= (((^shift) ^ samp) != (PARITY == 1));
        S_STOP: if (tick) begin
          if (!samp)    frm_err <= 1'b1;
          if (last_stop) done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output register: a completed frame loads if the slot is empty or being
  // drained this cycle; otherwise it is dropped and the held word kept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx.o_data    <= '0;
      rx.o_valid   <= 1'b0;
      rx.o_par_err <= 1'b0;
      rx.o_frm_err <= 1'b0;
      rx.o_overrun <= 1'b0;
    end else begin
      rx.o_overrun <= 1'b0;
      if (rx.o_valid && rx.i_ready) rx.o_valid <= 1'b0;
      if (done) begin
        if (!rx.o_valid || rx.i_ready) begin
          rx.o_data    <= shift;
          rx.o_par_err <= par_err;
          rx.o_frm_err <= frm_err;
          rx.o_valid   <= 1'b1;
        end else begin
          rx.o_overrun <= 1'b1;
        end
      end
    end
  end

endmodule
